// File: rtl/int_ctrl_if.sv
// Bus bundle between the decode/PC logic (master) and the interrupt controller (slave).
// Carries request lines, the retire/eret handshake and the redirect/save/restore controls.
interface int_ctrl_if;
    logic [2:0]  irq_in;
    logic [2:0]  mask;
    logic        retire;
    logic        eret;
    logic        take;
    logic [31:0] vector;
    logic        save_en;
    logic [1:0]  save_lvl;
    logic        restore;
    logic [1:0]  restore_lvl;
    logic [2:0]  running;
    logic [1:0]  cur_lvl;
    logic [2:0]  pending;
    logic        err;

    modport master (
        output irq_in, mask, retire, eret,
        input  take, vector, save_en, save_lvl, restore, restore_lvl,
               running, cur_lvl, pending, err
    );

    modport slave (
        input  irq_in, mask, retire, eret,
        output take, vector, save_en, save_lvl, restore, restore_lvl,
               running, cur_lvl, pending, err
    );
endinterface

// File: rtl/int_ctrl.sv
// Three-source nested interrupt controller: edge-latched requests, fixed priority
// preemption, and one-cycle take/save or restore pulses toward the PC logic.
module int_ctrl #(
    parameter logic [31:0] VEC1 = 32'h00000038,
    parameter logic [31:0] VEC2 = 32'h00000070,
    parameter logic [31:0] VEC3 = 32'h000000A8
) (
    input  logic        clk,
    input  logic        clr_n,
    int_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ENTER, EXIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  irq_q;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  running_q, running_d;
    logic        err_q, err_d;
    logic [31:0] vector_q, vector_d;
    logic [1:0]  save_lvl_q, save_lvl_d;
    logic [1:0]  restore_lvl_q, restore_lvl_d;

    logic [2:0]  edge_det;
    logic [2:0]  eligible;
    logic [2:0]  clr_pend;
    logic [1:0]  cur_lvl;
    logic [1:0]  req_lvl;

    // Level number (1..3) of the highest set bit, 0 when none is set.
    function automatic logic [1:0] top_idx(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [2:0] lvl_bit(input logic [1:0] lvl);
        return (lvl == 2'd0) ? 3'b000 : (3'b001 << (lvl - 2'd1));
    endfunction

    assign edge_det = bus.irq_in & ~irq_q;
    assign eligible = pending_q & ~bus.mask;
    assign cur_lvl  = top_idx(running_q);
    assign req_lvl  = top_idx(eligible);

    always_comb begin
        state_d       = state_q;
        running_d     = running_q;
        err_d         = err_q;
        vector_d      = vector_q;
        save_lvl_d    = save_lvl_q;
        restore_lvl_d = restore_lvl_q;
        clr_pend      = 3'b000;

        case (state_q)
            IDLE: begin
                // eret has precedence; a competing request simply stays pending.
                if (bus.eret) begin
                    if (cur_lvl == 2'd0) begin
                        err_d = 1'b1;
                    end else begin
                        running_d     = running_q & ~lvl_bit(cur_lvl);
                        restore_lvl_d = top_idx(running_q & ~lvl_bit(cur_lvl));
                        state_d       = EXIT;
                    end
                end else if (bus.retire && (req_lvl > cur_lvl)) begin
                    clr_pend   = lvl_bit(req_lvl);
                    running_d  = running_q | lvl_bit(req_lvl);
                    save_lvl_d = cur_lvl;
                    case (req_lvl)
                        2'd3:    vector_d = VEC3;
                        2'd2:    vector_d = VEC2;
                        default: vector_d = VEC1;
                    endcase
                    state_d = ENTER;
                end
            end
            ENTER:   state_d = IDLE;
            EXIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A fresh edge wins over the accept clear so no request is lost.
        pending_d = (pending_q & ~clr_pend) | edge_det;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= IDLE;
            irq_q         <= 3'b000;
            pending_q     <= 3'b000;
            running_q     <= 3'b000;
            err_q         <= 1'b0;
            vector_q      <= 32'h0;
            save_lvl_q    <= 2'd0;
            restore_lvl_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            irq_q         <= bus.irq_in;
            pending_q     <= pending_d;
            running_q     <= running_d;
            err_q         <= err_d;
            vector_q      <= vector_d;
            save_lvl_q    <= save_lvl_d;
            restore_lvl_q <= restore_lvl_d;
        end
    end

    assign bus.take        = (state_q == ENTER);
    assign bus.save_en     = (state_q == ENTER);
    assign bus.restore     = (state_q == EXIT);
    assign bus.vector      = vector_q;
    assign bus.save_lvl    = save_lvl_q;
    assign bus.restore_lvl = restore_lvl_q;
    assign bus.running     = running_q;
    assign bus.cur_lvl     = cur_lvl;
    assign bus.pending     = pending_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: per-cycle vector table plus a scoreboard
// of expected take/restore events, followed by reset-abort sequences.
module tb_int_ctrl;

    logic clk;
    logic clr_n;
    int_ctrl_if bus ();

    int_ctrl dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  irq;
        logic [2:0]  mask;
        logic        retire;
        logic        eret;
        logic [2:0]  pend;
        logic [2:0]  run;
        logic [1:0]  cur;
        logic        err;
        logic        take;
        logic        rst;
        logic [31:0] vec;
        logic [1:0]  lvl;
    } row_t;

    typedef struct {
        logic [31:0] vec;
        logic [1:0]  lvl;
    } take_t;

    row_t        tbl[$];
    take_t       take_q[$];
    logic [1:0]  rst_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic r(input logic [2:0] irq, input logic [2:0] mask, input logic retire,
                     input logic eret, input logic [2:0] pend, input logic [2:0] run,
                     input logic [1:0] cur, input logic err, input logic take,
                     input logic rst, input logic [31:0] vec, input logic [1:0] lvl);
        row_t x;
        x.irq = irq; x.mask = mask; x.retire = retire; x.eret = eret;
        x.pend = pend; x.run = run; x.cur = cur; x.err = err;
        x.take = take; x.rst = rst; x.vec = vec; x.lvl = lvl;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic [2:0] irq, input logic [2:0] mask,
                         input logic retire, input logic eret);
        bus.irq_in = irq;
        bus.mask   = mask;
        bus.retire = retire;
        bus.eret   = eret;
    endtask

    // Event monitor: pops the scoreboard whenever a pulse appears.
    always @(negedge clk) begin
        if (clr_n) begin
            chk("pulse_exclusive", {63'd0, bus.take & bus.restore}, 64'd0);
            if (bus.take) begin
                if (take_q.size() == 0) begin
                    chk("unexpected_take", {32'd0, bus.vector}, 64'd0);
                end else begin
                    take_t e;
                    e = take_q.pop_front();
                    chk("take_vector", {32'd0, bus.vector}, {32'd0, e.vec});
                    chk("take_save_lvl", {62'd0, bus.save_lvl}, {62'd0, e.lvl});
                end
            end
            if (bus.restore) begin
                if (rst_q.size() == 0) begin
                    chk("unexpected_restore", {62'd0, bus.restore_lvl}, 64'd9);
                end else begin
                    logic [1:0] el;
                    el = rst_q.pop_front();
                    chk("restore_lvl", {62'd0, bus.restore_lvl}, {62'd0, el});
                end
            end
        end
    end

    initial begin
        take_t t;

        // irq, mask, retire, eret | pending, running, cur_lvl, err, take, restore, vector, lvl
        r(3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 0, 0, 0, 0, 32'h0,  0); // src1 edge
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 0, 1, 0, 32'h38, 0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 0, 0, 0, 32'h0,  0);
        r(3'b010, 3'b000, 1, 0, 3'b010, 3'b001, 1, 0, 0, 0, 32'h0,  0); // nest src2
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b011, 2, 0, 1, 0, 32'h70, 1);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b011, 2, 0, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b001, 1, 0, 0, 1, 32'h0,  1);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 0, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 0, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 1, 0, 0, 32'h0,  0); // stray eret
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b101, 3'b000, 1, 0, 3'b101, 3'b000, 0, 1, 0, 0, 32'h0,  0); // src1+src3
        r(3'b000, 3'b000, 1, 0, 3'b001, 3'b100, 3, 1, 1, 0, 32'hA8, 0);
        r(3'b000, 3'b000, 1, 0, 3'b001, 3'b100, 3, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b001, 3'b100, 3, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b001, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 1, 1, 0, 32'h38, 0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b010, 3'b010, 1, 0, 3'b010, 3'b000, 0, 1, 0, 0, 32'h0,  0); // masked src2
        r(3'b000, 3'b010, 1, 0, 3'b010, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b010, 1, 0, 3'b010, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b010, 2, 1, 1, 0, 32'h70, 0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b010, 2, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b001, 3'b000, 0, 0, 3'b001, 3'b000, 0, 1, 0, 0, 32'h0,  0); // retire low
        r(3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 1, 1, 0, 32'h38, 0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 1, 0, 0, 32'h0,  0);
        r(3'b100, 3'b000, 1, 0, 3'b100, 3'b001, 1, 1, 0, 0, 32'h0,  0); // eret vs accept
        r(3'b000, 3'b000, 1, 1, 3'b100, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b100, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b100, 3, 1, 1, 0, 32'hA8, 0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b100, 3, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1, 0, 0, 32'h0,  0); // edge at accept
        r(3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b001, 3'b000, 1, 0, 3'b001, 3'b001, 1, 1, 1, 0, 32'h38, 0);
        r(3'b000, 3'b000, 1, 0, 3'b001, 3'b001, 1, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b001, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 1, 1, 0, 32'h38, 0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b001, 1, 1, 0, 0, 32'h0,  0);
        r(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 1, 0, 1, 32'h0,  0);
        r(3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 1, 0, 0, 32'h0,  0);

        clr_n = 1'b0;
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_state",
            {13'd0, bus.pending, bus.running, bus.cur_lvl, bus.err, bus.take, bus.save_en,
             bus.restore, bus.save_lvl, bus.restore_lvl, bus.vector}, 64'd0);
        clr_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].irq, tbl[i].mask, tbl[i].retire, tbl[i].eret);
            if (tbl[i].take) begin
                t.vec = tbl[i].vec;
                t.lvl = tbl[i].lvl;
                take_q.push_back(t);
            end
            if (tbl[i].rst) rst_q.push_back(tbl[i].lvl);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d", i),
                {50'd0, bus.pending, bus.running, bus.cur_lvl, bus.err,
                 bus.take, bus.save_en, bus.restore},
                {50'd0, tbl[i].pend, tbl[i].run, tbl[i].cur, tbl[i].err,
                 tbl[i].take, tbl[i].take, tbl[i].rst});
        end

        // Reset in the middle of ENTER kills the pulse at once.
        drive(3'b010, 3'b000, 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        t.vec = 32'h70; t.lvl = 2'd0;
        take_q.push_back(t);
        @(posedge clk); @(negedge clk);
        chk("enter_before_reset", {63'd0, bus.take}, 64'd1);
        #2 clr_n = 1'b0;
        drive(3'b100, 3'b000, 1'b1, 1'b0);
        #1;
        chk("reset_in_enter",
            {18'd0, bus.take, bus.save_en, bus.restore, bus.pending, bus.running,
             bus.err, bus.vector}, 64'd0);
        @(posedge clk); @(negedge clk);
        clr_n = 1'b1;

        // irq_in[2] held high through reset counts as a new edge.
        @(posedge clk); @(negedge clk);
        chk("held_irq_edge", {58'd0, bus.pending, bus.running}, {58'd0, 3'b100, 3'b000});
        drive(3'b100, 3'b000, 1'b1, 1'b1);
        t.vec = 32'hA8; t.lvl = 2'd0;
        @(posedge clk); @(negedge clk);
        chk("eret_wins_no_take", {60'd0, bus.take, bus.err, bus.restore, bus.pending == 3'b100},
            {60'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        drive(3'b100, 3'b000, 1'b1, 1'b0);
        take_q.push_back(t);
        @(posedge clk); @(negedge clk);
        chk("take_after_reset", {61'd0, bus.running}, {61'd0, 3'b100});
        drive(3'b100, 3'b000, 1'b1, 1'b1); // eret during ENTER is ignored
        @(posedge clk); @(negedge clk);
        chk("eret_in_enter_ignored", {59'd0, bus.running, bus.restore, bus.take},
            {59'd0, 3'b100, 1'b0, 1'b0});
        rst_q.push_back(2'd0);
        @(posedge clk); @(negedge clk);
        chk("exit_before_reset", {63'd0, bus.restore}, 64'd1);
        #2 clr_n = 1'b0;
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        #1;
        chk("reset_in_exit", {57'd0, bus.restore, bus.restore_lvl, bus.running, bus.err}, 64'd0);
        @(posedge clk); @(negedge clk);
        clr_n = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("no_partial_pulse", {61'd0, bus.take, bus.save_en, bus.restore}, 64'd0);
        end

        chk("take_queue_drained", 64'(take_q.size()), 64'd0);
        chk("restore_queue_drained", 64'(rst_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
